cyp_slfifo_rd: RTL and testbench
================================

Name: cyp_slfifo_rd

Overview:
- Read master for the CY68013 (FX2) synchronous slave FIFO; runs entirely in cyp_clk domain.
- Drains one FX2 OUT endpoint: drives slcs/sloe/slrd/fifoaddr and samples usb_fd_i.
- Buffers words in a 4-entry FIFO and presents them with a linear word address on a valid/ready stream (wr_data/wr_addr/wr_valid/wr_ready). That stream feeds the cyp_clk→sdram_clk crossing toward the SDRAM write controller.

Parameters:
- EP_ADDR, 2'b00: value driven on usb_fifoaddr while selected.
- BURST_LEN, 256: max words read per SEL..RELEASE cycle. Range 1..65535.
- BASE_ADDR, 22'd0: first wr_addr after reset.
- ADDR_LAST, 22'h3FFFFF: last address before wrap to BASE_ADDR. Must be ≥ BASE_ADDR.
- BUF_DEPTH, 4: output buffer depth. Power of two, ≥2.

Ports:
- cyp_clk  in  1  block clock, 48 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  level; 1 = allowed to start/continue reading.
- usb_fifoaddr  out  2  FX2 FIFOADR.
- usb_slcs  out  1  FX2 SLCS#, active low.
- usb_sloe  out  1  FX2 SLOE#, active low.
- usb_slrd  out  1  FX2 SLRD#, active low.
- usb_slwr  out  1  FX2 SLWR#; tied 1.
- usb_fd_i  in  16  FX2 FD bus, input half.
- usb_fd_oe  out  1  FD output enable; tied 0.
- usb_flaga  in  1  FX2 empty flag; 1 = endpoint not empty.
- wr_data  out  16  head word of buffer.
- wr_addr  out  22  word address of head word.
- wr_valid  out  1  buffer not empty.
- wr_ready  in  1  consumer accepts when wr_valid & wr_ready.
- rd_busy  out  1  1 in any state other than IDLE.

Behaviour:
- Reset: state=IDLE; usb_slcs=usb_sloe=usb_slrd=usb_slwr=1; usb_fifoaddr=EP_ADDR; usb_fd_oe=0; buffer empty; wr_valid=0; wr_data=0; wr_addr=BASE_ADDR; burst count=0; rd_busy=0.
- All outputs are registered except usb_slrd, wr_data and wr_addr.
  - usb_slrd = !(state==READ & usb_flaga & space). space = buffer count < BUF_DEPTH, or a pop occurs this cycle.
  - wr_data and wr_addr are buffer head read and pointer outputs.
- FSM:
  - IDLE → SEL when enable & usb_flaga. Burst count cleared.
  - SEL: slcs=0. Always → OE next cycle.
  - OE: slcs=0, sloe=0; FD turnaround cycle. Always → READ.
  - READ: slcs=0, sloe=0, slrd as above.
    - On each edge with slrd low: push usb_fd_i into the buffer and increment burst count.
    - Exit → RELEASE when any of: enable=0; usb_flaga=0; burst count reaches BURST_LEN, including the current push.
    - A stall for lack of space alone does not exit READ.
  - RELEASE: sloe=1, slcs=0, slrd=1. → IDLE next cycle, where slcs=1.
- Latency: enable & flaga sampled at edge e0 gives first slrd-low cycle after e2, first push at e3, wr_valid=1 after e3. With wr_ready=1 and flaga held: one word per cycle, no bubbles within a burst. Inter-burst overhead is 4 cycles (RELEASE, IDLE, SEL, OE).
- Buffer:
  - Simultaneous push and pop is allowed at full and at empty+1.
  - Never over-read: no push when full without a concurrent pop.
  - Never duplicate a word: exactly one push per slrd-low edge.
- Address:
  - wr_addr is the address of the head word.
  - On each pop, wr_addr ← (wr_addr==ADDR_LAST) ? BASE_ADDR : wr_addr+1.
- enable deasserted mid-burst: the current edge's push still completes, then RELEASE. Buffered words continue to drain regardless of enable.
- usb_flaga drop: slrd goes high the same cycle (combinational), then RELEASE.
- Reset mid-operation: immediate return to reset values. Buffered data is discarded and the address returns to BASE_ADDR.

Decomposition:
- Package cyp_pkg holds:
  - FSM state encoding: IDLE, SEL, OE, READ, RELEASE.
  - FX2 FIFOADR endpoint constants: EP2=0, EP4=1, EP6=2, EP8=3.
  - Data width 16 and address width 22.
- One sub-module: cyp_sync_fifo, a parameterised single-clock FIFO (depth, width) with count, full, empty and show-ahead head. It is reused later for the write-side block.

Test Plan:
- FX2 model: fd increments per slrd-low edge, flaga=!(fd==256). wr_ready=1, enable=1, BURST_LEN=256 → 256 words, data 0..255 with wr_addr 0..255. slrd high from the cycle flaga drops. FSM ends in IDLE with slcs=1.
- Same model, wr_ready=0 for 50 cycles, then 1 → exactly 4 words read, slrd held high while full, FSM stays in READ. After release, words 0..255 arrive in order with no gaps or duplicates.
- BURST_LEN=16, 40 words available → bursts of 16, 16 and 8, each with a SEL/OE/RELEASE sequence and 4-cycle overhead. Data is continuous 0..39.
- BASE_ADDR=8, ADDR_LAST=11, 10 words → wr_addr sequence 8,9,10,11,8,9,10,11,8,9.
- enable dropped at word 20 → push of word 20 completes, RELEASE next, no further slrd-low. Re-enable resumes at word 21.
- rst_n pulsed low during READ with 3 words buffered → all outputs at reset values asynchronously, wr_valid=0. After release, reading restarts at wr_addr=BASE_ADDR.

Source files
------------

// File: rtl/cyp_pkg.sv
// Shared types and constants for the CY68013 (FX2) slave-FIFO blocks.
// Holds the read-master state encoding, FIFOADR endpoint codes and bus widths.
package cyp_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 22;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEL,
        ST_OE,
        ST_READ,
        ST_RELEASE
    } rd_state_t;

    typedef enum logic [1:0] {
        EP2 = 2'd0,
        EP4 = 2'd1,
        EP6 = 2'd2,
        EP8 = 2'd3
    } fifoadr_t;

    // Linear word address with wrap from last back to base.
    function automatic logic [ADDR_W-1:0] next_addr(
        input logic [ADDR_W-1:0] addr,
        input logic [ADDR_W-1:0] base,
        input logic [ADDR_W-1:0] last
    );
        return (addr == last) ? base : addr + 1'b1;
    endfunction

endpackage

// File: rtl/cyp_slfifo_rd_if.sv
// FX2 slave-FIFO pins plus the buffered word stream of the read master.
// master = the read block, slave = the FX2 chip and the downstream consumer.
interface cyp_slfifo_rd_if;
    import cyp_pkg::*;

    logic [1:0]        usb_fifoaddr;
    logic              usb_slcs;
    logic              usb_sloe;
    logic              usb_slrd;
    logic              usb_slwr;
    logic [DATA_W-1:0] usb_fd_i;
    logic              usb_fd_oe;
    logic              usb_flaga;

    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_valid;
    logic              wr_ready;

    modport master (
        output usb_fifoaddr, usb_slcs, usb_sloe, usb_slrd, usb_slwr, usb_fd_oe,
        output wr_data, wr_addr, wr_valid,
        input  usb_fd_i, usb_flaga, wr_ready
    );

    modport slave (
        input  usb_fifoaddr, usb_slcs, usb_sloe, usb_slrd, usb_slwr, usb_fd_oe,
        input  wr_data, wr_addr, wr_valid,
        output usb_fd_i, usb_flaga, wr_ready
    );

endinterface

// File: rtl/cyp_sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy count; DEPTH must be a power of two >= 2.
// A push while full is dropped unless a pop happens on the same edge.
module cyp_sync_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             cyp_clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    // NOTE: the storage is reset too, so the show-ahead head reads zero after reset
    // instead of X; affordable only because the buffer is a handful of words.
    always_ff @(posedge cyp_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: state registers use non-blocking assignment so every register samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge cyp_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cyp_slfifo_rd.sv
// FX2 synchronous slave-FIFO read master: drains one OUT endpoint in bursts into a
// small buffer and presents each word with a wrapping linear address on a valid/ready stream.
module cyp_slfifo_rd
    import cyp_pkg::*;
#(
    parameter logic [1:0]        EP_ADDR   = 2'b00,
    parameter int                BURST_LEN = 256,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 22'd0,
    parameter logic [ADDR_W-1:0] ADDR_LAST = 22'h3FFFFF,
    parameter int                BUF_DEPTH = 4
) (
    input  logic                  cyp_clk,
    input  logic                  rst_n,
    input  logic                  enable,
    cyp_slfifo_rd_if.master       bus,
    output logic                  rd_busy
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

    rd_state_t         state;
    rd_state_t         state_nx;
    logic              burst_clr;
    logic              burst_last;
    logic [15:0]       burst_cnt;
    logic              slcs_q;
    logic              sloe_q;
    logic              busy_q;
    logic [ADDR_W-1:0] addr_q;

    logic [CNT_W-1:0]  buf_count;
    logic              buf_full;
    logic              buf_empty;
    logic              pop;
    logic              space;
    logic              read_en;

    assign pop        = bus.wr_valid & bus.wr_ready;
    assign space      = (buf_count < CNT_W'(BUF_DEPTH)) | pop;
    // SLRD# is the only combinational pin: it must rise in the same cycle FLAGA drops.
    assign read_en    = (state == ST_READ) & bus.usb_flaga & space;
    assign burst_last = read_en & (burst_cnt == 16'(BURST_LEN - 1));

    assign bus.usb_slrd     = ~read_en;
    assign bus.usb_slcs     = slcs_q;
    assign bus.usb_sloe     = sloe_q;
    assign bus.usb_slwr     = 1'b1;
    assign bus.usb_fd_oe    = 1'b0;
    assign bus.usb_fifoaddr = EP_ADDR;
    assign bus.wr_valid     = ~buf_empty;
    assign bus.wr_addr      = addr_q;
    assign rd_busy          = busy_q;

    cyp_sync_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (DATA_W)
    ) u_buf (
        .cyp_clk   (cyp_clk),
        .rst_n     (rst_n),
        .push      (read_en),
        .push_data (bus.usb_fd_i),
        .pop       (pop),
        .head      (bus.wr_data),
        .count     (buf_count),
        .full      (buf_full),
        .empty     (buf_empty)
    );

    // NOTE: every output of this block gets a default before the case, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_nx  = state;
        burst_clr = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable && bus.usb_flaga) begin
                    state_nx  = ST_SEL;
                    burst_clr = 1'b1;
                end
            end
            ST_SEL:     state_nx = ST_OE;
            ST_OE:      state_nx = ST_READ;
            ST_READ: begin
                // A stall for lack of buffer space alone keeps the endpoint selected.
                if (!enable || !bus.usb_flaga || burst_last) state_nx = ST_RELEASE;
            end
            ST_RELEASE: state_nx = ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    // Strobes are decoded from the next state so they come straight from flops.
    always_ff @(posedge cyp_clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            slcs_q <= 1'b1;
            sloe_q <= 1'b1;
            busy_q <= 1'b0;
        end else begin
            state  <= state_nx;
            slcs_q <= (state_nx == ST_IDLE);
            sloe_q <= !((state_nx == ST_OE) || (state_nx == ST_READ));
            busy_q <= (state_nx != ST_IDLE);
        end
    end

    always_ff @(posedge cyp_clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_cnt <= '0;
        end else if (burst_clr) begin
            burst_cnt <= '0;
        end else if (read_en) begin
            burst_cnt <= burst_cnt + 1'b1;
        end
    end

    always_ff @(posedge cyp_clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= BASE_ADDR;
        end else if (pop) begin
            addr_q <= next_addr(addr_q, BASE_ADDR, ADDR_LAST);
        end
    end

    never_overread: assert property (@(posedge cyp_clk) disable iff (!rst_n)
        (read_en && buf_full) |-> pop);

endmodule

// File: tb/tb_cyp_slfifo_rd.sv
// Bench for cyp_slfifo_rd: an FX2 endpoint model feeds an incrementing word stream and
// a scoreboard predicts every delivered word and its wrapping address.
module tb_cyp_slfifo_rd;
    import cyp_pkg::*;

    localparam int                BLEN = 16;
    localparam logic [ADDR_W-1:0] BASE = 22'd8;
    localparam logic [ADDR_W-1:0] LAST = 22'd11;
    localparam int                SPAN = 4;
    localparam logic [1:0]        EP   = EP6;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
    } exp_t;

    logic cyp_clk = 1'b0;
    logic rst_n   = 1'b0;
    logic enable  = 1'b0;
    logic rd_busy;

    cyp_slfifo_rd_if bus ();

    cyp_slfifo_rd #(
        .EP_ADDR   (EP),
        .BURST_LEN (BLEN),
        .BASE_ADDR (BASE),
        .ADDR_LAST (LAST),
        .BUF_DEPTH (4)
    ) dut (
        .cyp_clk (cyp_clk),
        .rst_n   (rst_n),
        .enable  (enable),
        .bus     (bus),
        .rd_busy (rd_busy)
    );

    always #5 cyp_clk = ~cyp_clk;

    // FX2 endpoint model: the word on FD counts reads; FLAGA is high while words remain.
    int   fd_cnt = 0;
    int   avail  = 0;
    logic take   = 1'b0;
    assign bus.usb_fd_i  = fd_cnt[15:0];
    assign bus.usb_flaga = (fd_cnt != avail);
    always @(posedge cyp_clk) if (take) fd_cnt <= fd_cnt + 1;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];
    int   n_words = 0;
    int   cyc = 0;
    int   rd_cycles[$];
    logic log_reads   = 1'b0;
    logic chk_no_read = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor + scoreboard, sampled on the falling edge.
    exp_t mon_e;
    exp_t mon_p;
    int   mon_occ;
    logic mon_pop;
    always @(negedge cyp_clk) begin
        cyc++;
        take = 1'b0;
        if (rst_n) begin
            mon_occ = exp_q.size();
            mon_pop = bus.wr_valid && bus.wr_ready;
            check("wr_valid", bus.wr_valid, mon_occ != 0);
            check("static_pins", {bus.usb_slwr, bus.usb_fd_oe, bus.usb_fifoaddr}, {1'b1, 1'b0, EP});
            if (chk_no_read) check("slrd_after_disable", bus.usb_slrd, 1'b1);
            if (mon_pop) begin
                if (mon_occ == 0) begin
                    check("pop_unexpected", 1'b1, 1'b0);
                end else begin
                    mon_p = exp_q.pop_front();
                    check("wr_data", bus.wr_data, mon_p.data);
                    check("wr_addr", bus.wr_addr, mon_p.addr);
                end
            end
            if (!bus.usb_slrd) begin
                check("slrd_ctl", {bus.usb_slcs, bus.usb_sloe, bus.usb_flaga}, 3'b001);
                check("no_overread", (mon_occ < 4) || mon_pop, 1'b1);
                mon_e.data = fd_cnt[15:0];
                mon_e.addr = BASE + ADDR_W'(n_words % SPAN);
                exp_q.push_back(mon_e);
                n_words++;
                take = 1'b1;
                if (log_reads) rd_cycles.push_back(cyc);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge cyp_clk);
        #1;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while ((fd_cnt != avail || exp_q.size() != 0) && n < budget) begin
            @(posedge cyp_clk);
            n++;
        end
        #1;
        check(name, n < budget, 1'b1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_slcs"},     bus.usb_slcs, 1'b1);
        check({tag, "_sloe"},     bus.usb_sloe, 1'b1);
        check({tag, "_slrd"},     bus.usb_slrd, 1'b1);
        check({tag, "_wr_valid"}, bus.wr_valid, 1'b0);
        check({tag, "_wr_data"},  bus.wr_data, 16'd0);
        check({tag, "_wr_addr"},  bus.wr_addr, BASE);
        check({tag, "_rd_busy"},  rd_busy, 1'b0);
    endtask

    task automatic test_burst_shape();
        int runs[$];
        int gaps[$];
        int exp_runs[3] = '{16, 16, 8};
        int len = 1;
        rd_cycles.delete();
        log_reads = 1'b1;
        avail = fd_cnt + 40;
        wait_drain("burst_drain", 2000);
        log_reads = 1'b0;
        for (int i = 1; i < rd_cycles.size(); i++) begin
            if (rd_cycles[i] - rd_cycles[i-1] == 1) len++;
            else begin
                runs.push_back(len);
                gaps.push_back(rd_cycles[i] - rd_cycles[i-1]);
                len = 1;
            end
        end
        if (rd_cycles.size() > 0) runs.push_back(len);
        check("burst_count", runs.size(), 3);
        for (int i = 0; i < runs.size() && i < 3; i++) check($sformatf("burst_len%0d", i), runs[i], exp_runs[i]);
        foreach (gaps[i]) check($sformatf("burst_gap%0d", i), gaps[i], 5);
    endtask

    task automatic test_enable_drop();
        int start = fd_cnt;
        int n = 0;
        avail = fd_cnt + 40;
        while (!(!bus.usb_slrd && fd_cnt == start + 20) && n < 500) begin
            @(negedge cyp_clk);
            n++;
        end
        check("en_reach_word20", n < 500, 1'b1);
        enable = 1'b0;
        tick(1);
        check("en_word20_pushed", fd_cnt - start, 21);
        chk_no_read = 1'b1;
        tick(10);
        check("en_no_more_reads", fd_cnt - start, 21);
        check("en_idle_slcs", bus.usb_slcs, 1'b1);
        chk_no_read = 1'b0;
        enable = 1'b1;
        n = 0;
        @(negedge cyp_clk);
        while (bus.usb_slrd && n < 100) begin
            @(negedge cyp_clk);
            n++;
        end
        check("en_resume_word", bus.usb_fd_i, 16'(start + 21));
        wait_drain("en_drain", 2000);
    endtask

    task automatic test_reset_mid_read();
        int n = 0;
        bus.wr_ready = 1'b0;
        avail = fd_cnt + 40;
        while (exp_q.size() != 3 && n < 200) begin
            @(negedge cyp_clk);
            n++;
        end
        check("rst_reach_3", exp_q.size(), 3);
        @(posedge cyp_clk);
        #1;
        check("rst_in_read", {rd_busy, bus.usb_sloe}, 2'b10);
        rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        exp_q.delete();
        n_words = 0;
        @(negedge cyp_clk);
        #1;
        rst_n = 1'b1;
        bus.wr_ready = 1'b1;
        n = 0;
        while (!bus.wr_valid && n < 50) begin
            @(posedge cyp_clk);
            #1;
            n++;
        end
        check("post_reset_addr", bus.wr_addr, BASE);
        wait_drain("rst_drain", 2000);
    endtask

    initial begin
        bus.wr_ready = 1'b0;
        #23;
        check_reset_values("reset");
        @(negedge cyp_clk);
        rst_n = 1'b1;
        tick(2);

        // Long transfer with a consumer that is always ready: 256 words in bursts.
        enable = 1'b1;
        bus.wr_ready = 1'b1;
        avail = 256;
        wait_drain("full_drain", 3000);
        tick(4);
        check("end_idle_slcs", bus.usb_slcs, 1'b1);
        check("end_idle_busy", rd_busy, 1'b0);

        // Back-pressure: the buffer fills and the read strobe stalls inside READ.
        begin : stall
            int start;
            bus.wr_ready = 1'b0;
            start = fd_cnt;
            avail = fd_cnt + 64;
            tick(50);
            check("stall_words", fd_cnt - start, 4);
            check("stall_slrd", bus.usb_slrd, 1'b1);
            check("stall_in_read", {rd_busy, bus.usb_slcs, bus.usb_sloe}, 3'b100);
            bus.wr_ready = 1'b1;
            wait_drain("stall_drain", 2000);
        end

        test_burst_shape();
        test_enable_drop();
        test_reset_mid_read();

        // Random consumer stalls, endpoint refills and enable toggles.
        for (int i = 0; i < 1500; i++) begin
            tick(1);
            bus.wr_ready = ($urandom_range(0, 3) != 0);
            enable = ($urandom_range(0, 31) != 0);
            if ($urandom_range(0, 15) == 0 && (avail - fd_cnt) < 30) avail = avail + int'($urandom_range(1, 24));
        end
        enable = 1'b1;
        bus.wr_ready = 1'b1;
        wait_drain("rand_drain", 3000);
        check("final_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
